// File: rtl/vip_i2c_mem_s_pkg.sv
// Shared types and constants for the I2C memory slave model.
package vip_i2c_mem_s_pkg;

  // Pad buffer direction encoding: 1 releases the line, 0 drives it.
  localparam logic PIN_DIR_INPUT  = 1'b1;
  localparam logic PIN_DIR_OUTPUT = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HEADER,
    ST_ACK_HDR,
    ST_PTR,
    ST_ACK_PTR,
    ST_RX,
    ST_ACK_RX,
    ST_TX,
    ST_WAIT_ACK,
    ST_STRETCH,
    ST_SKIP
  } state_e;

  // Protocol registers (memory array lives separately in the top level).
  // ptr is kept 8 bits wide so the struct does not depend on DEPTH; it is
  // always masked to the memory size.
  typedef struct packed {
    state_e      state;
    state_e      nxt;       // state to resume after a stretch
    logic [3:0]  bit_cnt;   // bits still to receive / drive in the byte
    logic [7:0]  shreg;
    logic        rw;
    logic [7:0]  ptr;
    logic        sda_dir;
    logic        scl_dir;
    logic        busy;
    logic [15:0] str_cnt;
  } regs_t;

  localparam regs_t REGS_RST = '{
    state:   ST_IDLE,
    nxt:     ST_IDLE,
    bit_cnt: 4'd8,
    shreg:   8'h00,
    rw:      1'b0,
    ptr:     8'h00,
    sda_dir: PIN_DIR_INPUT,
    scl_dir: PIN_DIR_INPUT,
    busy:    1'b0,
    str_cnt: 16'd0
  };

  // Pointer increment with wrap at the (power-of-two) memory size.
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input logic [7:0] mask);
    return (ptr + 8'd1) & mask;
  endfunction

endpackage

// File: rtl/vip_i2c_mem_s_if.sv
// I2C pin bundle between the bench pad models and the slave model.
interface vip_i2c_mem_s_if;
  logic i_scl;
  logic i_sda;
  logic o_sda;
  logic o_sda_dir;
  logic o_scl;
  logic o_scl_dir;

  modport slave  (input i_scl, i_sda, output o_sda, o_sda_dir, o_scl, o_scl_dir);
  modport master (output i_scl, i_sda, input o_sda, o_sda_dir, o_scl, o_scl_dir);
endinterface

// File: rtl/vip_i2c_pin_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter: the output
// level only follows the input after FILTER_LEN consecutive differing samples.
module vip_i2c_pin_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level
);

  localparam logic [3:0] LP_CNT_MAX = 4'(FILTER_LEN - 1);

  logic [1:0] r_sync;
  logic [3:0] r_cnt;
  logic       r_level;

  // Synchronise the pin and update the filtered level after a stable run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_cnt   <= 4'd0;
      r_level <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      if (r_sync[1] == r_level) begin
        r_cnt <= 4'd0;
      end else if (r_cnt == LP_CNT_MAX) begin
        r_level <= r_sync[1];
        r_cnt   <= 4'd0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/vip_i2c_mem_s.sv
// I2C slave model with a byte memory, register pointer, repeated start,
// input glitch filtering and optional SCL stretching after each ACK bit.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | bus free, waiting for START
// HEADER      | shifting in address + R/W
// ACK_HDR     | driving ACK for our address
// PTR         | shifting in register pointer
// ACK_PTR     | driving ACK for the pointer byte
// RX          | shifting in a data byte
// ACK_RX      | driving ACK for a data byte
// TX          | driving a memory byte MSB first
// WAIT_ACK    | sampling the master ACK/NACK
// STRETCH     | holding SCL low, then resume nxt
// SKIP        | not addressed / NACKed, wait for START or STOP
module vip_i2c_mem_s
  import vip_i2c_mem_s_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h50,
  parameter int         DEPTH          = 16,
  parameter int         FILTER_LEN     = 3,
  parameter int         STRETCH_CYCLES = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  vip_i2c_mem_s_if.slave           io_bus,
  output logic                     o_busy,
  output logic                     o_wr_valid,
  output logic [$clog2(DEPTH)-1:0] o_wr_addr,
  output logic [7:0]               o_wr_data
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [7:0]  LP_MASK     = 8'(DEPTH - 1);
  localparam bit          LP_STRETCH  = (STRETCH_CYCLES > 0);
  localparam logic [15:0] LP_STR_LAST = 16'(STRETCH_CYCLES - 1);

  logic          w_scl_f, w_sda_f;
  logic          r_scl_q, r_sda_q;
  logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_ack_end, w_mem_we;
  logic [7:0]    w_mem_rd;
  regs_t         r_q;
  logic [7:0]    r_mem [DEPTH];
  logic          r_wr_valid;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;

  vip_i2c_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_flt_scl (
    .i_clk(i_clk), .i_rst(i_rst), .i_pin(io_bus.i_scl), .o_level(w_scl_f)
  );
  vip_i2c_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_flt_sda (
    .i_clk(i_clk), .i_rst(i_rst), .i_pin(io_bus.i_sda), .o_level(w_sda_f)
  );

  // Delayed copies of the filtered levels for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= w_scl_f;
      r_sda_q <= w_sda_f;
    end
  end

  assign w_scl_rise = w_scl_f & ~r_scl_q;
  assign w_scl_fall = ~w_scl_f & r_scl_q;
  assign w_start    = w_scl_f & r_scl_q & r_sda_q & ~w_sda_f;
  assign w_stop     = w_scl_f & r_scl_q & ~r_sda_q & w_sda_f;
  assign w_mem_rd   = r_mem[r_q.ptr[AW-1:0]];
  assign w_mem_we   = (r_q.state == ST_RX) && w_scl_fall && (r_q.bit_cnt == 4'd0);
  assign w_ack_end  = w_scl_fall && (r_q.state == ST_ACK_HDR || r_q.state == ST_ACK_PTR ||
                                     r_q.state == ST_ACK_RX  || r_q.state == ST_WAIT_ACK);

  // Protocol FSM; bus conditions are ignored while we hold SCL low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= REGS_RST;
    end else if ((w_start || w_stop) && r_q.state != ST_STRETCH) begin
      r_q.sda_dir <= PIN_DIR_INPUT;
      r_q.scl_dir <= PIN_DIR_INPUT;
      r_q.bit_cnt <= 4'd8;
      r_q.state   <= w_start ? ST_HEADER : ST_IDLE;
      r_q.busy    <= w_start;
    end else begin
      case (r_q.state)
        ST_HEADER, ST_PTR, ST_RX: begin
          if (w_scl_rise && r_q.bit_cnt != 4'd0) begin
            r_q.shreg   <= {r_q.shreg[6:0], w_sda_f};
            r_q.bit_cnt <= r_q.bit_cnt - 4'd1;
          end else if (w_scl_fall && r_q.bit_cnt == 4'd0) begin
            if (r_q.state == ST_HEADER) begin
              if (r_q.shreg[7:1] == DEV_ADDR) begin
                r_q.sda_dir <= PIN_DIR_OUTPUT;
                r_q.rw      <= r_q.shreg[0];
                r_q.state   <= ST_ACK_HDR;
              end else begin
                r_q.state <= ST_SKIP;
                r_q.busy  <= 1'b0;
              end
            end else if (r_q.state == ST_PTR) begin
              r_q.ptr     <= r_q.shreg & LP_MASK;
              r_q.sda_dir <= PIN_DIR_OUTPUT;
              r_q.state   <= ST_ACK_PTR;
            end else begin
              r_q.ptr     <= ptr_inc(r_q.ptr, LP_MASK);
              r_q.sda_dir <= PIN_DIR_OUTPUT;
              r_q.state   <= ST_ACK_RX;
            end
          end
        end
        ST_ACK_HDR: begin
          if (w_scl_fall) begin
            if (r_q.rw) begin
              // First read bit goes out on this same fall, before any stretch ends.
              r_q.shreg   <= {w_mem_rd[6:0], 1'b0};
              r_q.sda_dir <= w_mem_rd[7] ? PIN_DIR_INPUT : PIN_DIR_OUTPUT;
              r_q.bit_cnt <= 4'd7;
              r_q.nxt     <= ST_TX;
              r_q.state   <= LP_STRETCH ? ST_STRETCH : ST_TX;
            end else begin
              r_q.sda_dir <= PIN_DIR_INPUT;
              r_q.bit_cnt <= 4'd8;
              r_q.nxt     <= ST_PTR;
              r_q.state   <= LP_STRETCH ? ST_STRETCH : ST_PTR;
            end
          end
        end
        ST_ACK_PTR, ST_ACK_RX: begin
          if (w_scl_fall) begin
            r_q.sda_dir <= PIN_DIR_INPUT;
            r_q.bit_cnt <= 4'd8;
            r_q.nxt     <= ST_RX;
            r_q.state   <= LP_STRETCH ? ST_STRETCH : ST_RX;
          end
        end
        ST_TX: begin
          if (w_scl_fall) begin
            if (r_q.bit_cnt != 4'd0) begin
              r_q.sda_dir <= r_q.shreg[7] ? PIN_DIR_INPUT : PIN_DIR_OUTPUT;
              r_q.shreg   <= {r_q.shreg[6:0], 1'b0};
              r_q.bit_cnt <= r_q.bit_cnt - 4'd1;
            end else begin
              r_q.sda_dir <= PIN_DIR_INPUT;
              r_q.ptr     <= ptr_inc(r_q.ptr, LP_MASK);
              r_q.state   <= ST_WAIT_ACK;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (w_scl_rise && w_sda_f) begin
            r_q.state <= ST_SKIP;
            r_q.busy  <= 1'b0;
          end else if (w_scl_fall) begin
            r_q.shreg   <= {w_mem_rd[6:0], 1'b0};
            r_q.sda_dir <= w_mem_rd[7] ? PIN_DIR_INPUT : PIN_DIR_OUTPUT;
            r_q.bit_cnt <= 4'd7;
            r_q.nxt     <= ST_TX;
            r_q.state   <= LP_STRETCH ? ST_STRETCH : ST_TX;
          end
        end
        ST_STRETCH: begin
          if (r_q.str_cnt == 16'd0) begin
            r_q.scl_dir <= PIN_DIR_INPUT;
            r_q.state   <= r_q.nxt;
          end else begin
            r_q.str_cnt <= r_q.str_cnt - 16'd1;
          end
        end
        default: ;
      endcase
      if (LP_STRETCH && w_ack_end) begin
        r_q.scl_dir <= PIN_DIR_OUTPUT;
        r_q.str_cnt <= LP_STR_LAST;
      end
    end
  end

  // Memory write and write-monitor strobe, updated on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'(i);
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
    end else begin
      r_wr_valid <= w_mem_we;
      if (w_mem_we) begin
        r_mem[r_q.ptr[AW-1:0]] <= r_q.shreg;
        r_wr_addr              <= r_q.ptr[AW-1:0];
        r_wr_data              <= r_q.shreg;
      end
    end
  end

  assign io_bus.o_sda     = 1'b0;
  assign io_bus.o_scl     = 1'b0;
  assign io_bus.o_sda_dir = r_q.sda_dir;
  assign io_bus.o_scl_dir = r_q.scl_dir;
  assign o_busy           = r_q.busy;
  assign o_wr_valid       = r_wr_valid;
  assign o_wr_addr        = r_wr_addr;
  assign o_wr_data        = r_wr_data;

endmodule

// File: tb/tb_vip_i2c_mem_s.sv
// Directed bench: a simple I2C master drives a shared open-drain bus with two
// slave models (0x50 without stretching, 0x52 with 40-cycle stretching).
module tb_vip_i2c_mem_s;
  import vip_i2c_mem_s_pkg::*;

  localparam int T = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  always #5 clk = ~clk;

  vip_i2c_mem_s_if bus_a();
  vip_i2c_mem_s_if bus_b();

  logic       busy_a, wv_a, busy_b, wv_b;
  logic [3:0] wa_a, wa_b;
  logic [7:0] wd_a, wd_b;

  wire scl_line = m_scl & (bus_a.o_scl_dir ? 1'b1 : bus_a.o_scl) & (bus_b.o_scl_dir ? 1'b1 : bus_b.o_scl);
  wire sda_line = m_sda & (bus_a.o_sda_dir ? 1'b1 : bus_a.o_sda) & (bus_b.o_sda_dir ? 1'b1 : bus_b.o_sda);

  assign bus_a.i_scl = scl_line;
  assign bus_a.i_sda = sda_line;
  assign bus_b.i_scl = scl_line;
  assign bus_b.i_sda = sda_line;

  vip_i2c_mem_s #(.DEV_ADDR(7'h50)) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus_a), .o_busy(busy_a),
    .o_wr_valid(wv_a), .o_wr_addr(wa_a), .o_wr_data(wd_a)
  );

  vip_i2c_mem_s #(.DEV_ADDR(7'h52), .STRETCH_CYCLES(40)) dut_s (
    .i_clk(clk), .i_rst(rst_s), .io_bus(bus_b), .o_busy(busy_b),
    .o_wr_valid(wv_b), .o_wr_addr(wa_b), .o_wr_data(wd_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitors
  logic [11:0] wr_q[$];
  int sda_drv_a = 0;
  int busy_cnt = 0;
  int run = 0;
  int last_run = 0;
  int n_runs = 0;

  always @(negedge clk) begin
    if (wv_a) wr_q.push_back({wa_a, wd_a});
    if (bus_a.o_sda_dir == PIN_DIR_OUTPUT) sda_drv_a++;
    if (busy_a || busy_b) busy_cnt++;
    if (bus_b.o_scl_dir == PIN_DIR_OUTPUT) run++;
    else if (run != 0) begin
      last_run = run;
      n_runs++;
      run = 0;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int k = 0;
    while (!scl_line && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!scl_line) chk("scl_release_timeout", 32'(scl_line), 32'd1);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_clks(T);
    m_scl = 1'b1;
    wait_scl_high();
    wait_clks(T);
    m_sda = 1'b0;
    wait_clks(2 * T);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_clks(T);
    m_scl = 1'b1;
    wait_scl_high();
    wait_clks(T);
    m_sda = 1'b1;
    wait_clks(2 * T);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    wait_clks(T);
    m_sda = b;
    wait_clks(T);
    m_scl = 1'b1;
    wait_scl_high();
    wait_clks(T);
    r = sda_line;
    wait_clks(T);
    m_scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], dummy);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic b, dummy;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, b);
      d[i] = b;
    end
    bit_xfer(nack, dummy);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, b;
    logic [7:0] d;

    wait_clks(5);
    rst = 1'b0;
    rst_s = 1'b0;
    wait_clks(2);
    wr_q.delete();
    sda_drv_a = 0;
    busy_cnt = 0;
    run = 0;
    last_run = 0;
    n_runs = 0;

    // Reset state
    chk("rst_sda",     32'(bus_a.o_sda),     32'd0);
    chk("rst_scl",     32'(bus_a.o_scl),     32'd0);
    chk("rst_sda_dir", 32'(bus_a.o_sda_dir), 32'd1);
    chk("rst_scl_dir", 32'(bus_a.o_scl_dir), 32'd1);
    chk("rst_busy",    32'(busy_a),          32'd0);
    chk("rst_wr_valid",32'(wv_a),            32'd0);
    chk("rst_wr_addr", 32'(wa_a),            32'd0);
    chk("rst_wr_data", 32'(wd_a),            32'd0);
    chk("rst_s_scl_dir", 32'(bus_b.o_scl_dir), 32'd1);

    // Write ptr 03h, data AAh 55h
    i2c_start();
    wr_byte(8'hA0, ack); chk("w1_hdr_ack", 32'(ack), 32'd0);
    chk("w1_busy", 32'(busy_a), 32'd1);
    wr_byte(8'h03, ack); chk("w1_ptr_ack", 32'(ack), 32'd0);
    wr_byte(8'hAA, ack); chk("w1_d0_ack", 32'(ack), 32'd0);
    wr_byte(8'h55, ack); chk("w1_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    chk("w1_wr_count", 32'(wr_q.size()), 32'd2);
    chk("w1_wr0", 32'(wr_q.size() > 0 ? wr_q[0] : 12'hFFF), 32'h3AA);
    chk("w1_wr1", 32'(wr_q.size() > 1 ? wr_q[1] : 12'hFFF), 32'h455);
    chk("w1_addr_hold", 32'(wa_a), 32'h4);
    chk("w1_data_hold", 32'(wd_a), 32'h55);
    chk("w1_busy_idle", 32'(busy_a), 32'd0);

    // Pointer 0Eh, repeated start, read 3 with wrap
    i2c_start();
    wr_byte(8'hA0, ack); chk("r2_hdr_ack", 32'(ack), 32'd0);
    wr_byte(8'h0E, ack); chk("r2_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    wr_byte(8'hA1, ack); chk("r2_rhdr_ack", 32'(ack), 32'd0);
    chk("r2_busy", 32'(busy_a), 32'd1);
    rd_byte(1'b0, d); chk("r2_byte0", 32'(d), 32'h0E);
    rd_byte(1'b0, d); chk("r2_byte1", 32'(d), 32'h0F);
    rd_byte(1'b1, d); chk("r2_byte2_wrap", 32'(d), 32'h00);
    i2c_stop();
    chk("r2_busy_after_stop", 32'(busy_a), 32'd0);
    chk("r2_no_writes", 32'(wr_q.size()), 32'd2);

    // Wrong address: never driven, no writes
    sda_drv_a = 0;
    i2c_start();
    wr_byte(8'hA2, ack); chk("n3_hdr_nack", 32'(ack), 32'd1);
    wr_byte(8'h07, ack); chk("n3_data_nack", 32'(ack), 32'd1);
    i2c_stop();
    chk("n3_sda_never_driven", 32'(sda_drv_a), 32'd0);
    chk("n3_no_writes", 32'(wr_q.size()), 32'd2);

    // Pointer preserved across STOP
    i2c_start();
    wr_byte(8'hA0, ack); chk("p4_hdr_ack", 32'(ack), 32'd0);
    wr_byte(8'h05, ack); chk("p4_ptr_ack", 32'(ack), 32'd0);
    i2c_stop();
    i2c_start();
    wr_byte(8'hA1, ack); chk("p4_rhdr_ack", 32'(ack), 32'd0);
    rd_byte(1'b1, d); chk("p4_byte", 32'(d), 32'h05);
    i2c_stop();

    // 2-cycle SDA glitches while SCL high
    wait_clks(20);
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      m_sda = 1'b0;
      wait_clks(2);
      m_sda = 1'b1;
      wait_clks(12);
    end
    wait_clks(20);
    chk("g5_no_start", 32'(busy_cnt), 32'd0);

    // Stretch after header ACK, then reset mid-read-byte
    i2c_start();
    wr_byte(8'hA5, ack); chk("s6_hdr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bit_xfer(1'b1, b);
      chk("s6_read_bit", 32'(b), 32'd0);
    end
    chk("s6_stretch_len", 32'(last_run), 32'd40);
    chk("s6_stretch_runs", 32'(n_runs), 32'd1);
    wait_clks(T);
    chk("s6_sda_driven", 32'(bus_b.o_sda_dir), 32'(PIN_DIR_OUTPUT));
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    chk("s6_rst_sda_dir", 32'(bus_b.o_sda_dir), 32'(PIN_DIR_INPUT));
    chk("s6_rst_scl_dir", 32'(bus_b.o_scl_dir), 32'(PIN_DIR_INPUT));
    wait_clks(2);
    rst_s = 1'b0;
    i2c_stop();
    chk("s6_busy_idle", 32'(busy_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
